// File: rtl/logicgate_pkg.sv
// Shared gate-index constants and a reference gate evaluator for the logicgate bank.
package logicgate_pkg;

    localparam int unsigned NUM_GATES  = 7;
    localparam int unsigned GATE_IDX_W = 3;
    // Widest operand the evaluator handles; callers truncate to their own WIDTH.
    localparam int unsigned MAX_WIDTH  = 64;

    localparam logic [GATE_IDX_W-1:0] GATE_AND   = 3'd0;
    localparam logic [GATE_IDX_W-1:0] GATE_OR    = 3'd1;
    localparam logic [GATE_IDX_W-1:0] GATE_NAND  = 3'd2;
    localparam logic [GATE_IDX_W-1:0] GATE_NOR   = 3'd3;
    localparam logic [GATE_IDX_W-1:0] GATE_XOR   = 3'd4;
    localparam logic [GATE_IDX_W-1:0] GATE_XNOR  = 3'd5;
    localparam logic [GATE_IDX_W-1:0] GATE_NOT_A = 3'd6;

    // Bitwise result of gate idx; bits above the caller's width are don't-care.
    function automatic logic [MAX_WIDTH-1:0] gate_eval(
        input logic [GATE_IDX_W-1:0] idx,
        input logic [MAX_WIDTH-1:0]  a,
        input logic [MAX_WIDTH-1:0]  b
    );
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        case (idx)
            GATE_AND:   r = a & b;
            GATE_OR:    r = a | b;
            GATE_NAND:  r = ~(a & b);
            GATE_NOR:   r = ~(a | b);
            GATE_XOR:   r = a ^ b;
            GATE_XNOR:  r = ~(a ^ b);
            GATE_NOT_A: r = ~a;
            default:    r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logicgate_core.sv
// Purely combinational bank producing all gate results of one operand pair.
module logicgate_core
    import logicgate_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0]                 a,
    input  logic [WIDTH-1:0]                 b,
    output logic [NUM_GATES-1:0][WIDTH-1:0] res
);

    always_comb begin
        res = '0;
        for (int unsigned k = 0; k < NUM_GATES; k++) begin
            res[k] = WIDTH'(gate_eval(GATE_IDX_W'(k), MAX_WIDTH'(a), MAX_WIDTH'(b)));
        end
    end

endmodule

// File: rtl/logicgate.sv
// Two-input bitwise gate bank with an optional synchronous-reset output register.
module logicgate
    import logicgate_pkg::*;
#(
    parameter int unsigned WIDTH   = 1,
    parameter int unsigned REG_OUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output logic [WIDTH-1:0] i
);

    logic [NUM_GATES-1:0][WIDTH-1:0] res;
    logic [NUM_GATES-1:0][WIDTH-1:0] res_out;

    logicgate_core #(.WIDTH(WIDTH)) u_core (
        .a   (a),
        .b   (b),
        .res (res)
    );

    if (REG_OUT != 0) begin : g_reg
        // Reset clears every output, including those whose gate value would be one.
        logic [NUM_GATES-1:0][WIDTH-1:0] res_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                res_q <= '0;
            end else begin
                res_q <= res;
            end
        end
        assign res_out = res_q;
    end else begin : g_comb
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, rst};
        assign res_out   = res;
    end

    assign c = res_out[GATE_AND];
    assign d = res_out[GATE_OR];
    assign e = res_out[GATE_NAND];
    assign f = res_out[GATE_NOR];
    assign g = res_out[GATE_XOR];
    assign h = res_out[GATE_XNOR];
    assign i = res_out[GATE_NOT_A];

endmodule

// File: tb/tb_logicgate.sv
// Self-checking bench for logicgate: directed vectors plus shuffled exhaustive WIDTH=4 sweep.
module tb_logicgate;

    int n_tests = 0;
    int n_fail  = 0;

    logic clk   = 1'b0;
    logic clk_c = 1'b0;
    logic rst   = 1'b1;
    logic rst_c = 1'b0;

    always #5 clk = ~clk;

    // combinational WIDTH=1
    logic a1, b1, c1_c, c1_d, c1_e, c1_f, c1_g, c1_h, c1_i;
    // combinational WIDTH=8
    logic [7:0] a8, b8, c8_c, c8_d, c8_e, c8_f, c8_g, c8_h, c8_i;
    // combinational WIDTH=4
    logic [3:0] a4, b4, c4_c, c4_d, c4_e, c4_f, c4_g, c4_h, c4_i;
    // registered WIDTH=1
    logic ar1, br1, r1_c, r1_d, r1_e, r1_f, r1_g, r1_h, r1_i;
    // registered WIDTH=4
    logic [3:0] ar4, br4, r4_c, r4_d, r4_e, r4_f, r4_g, r4_h, r4_i;

    logicgate #(.WIDTH(1), .REG_OUT(0)) u_c1 (
        .clk(clk_c), .rst(rst_c), .a(a1), .b(b1),
        .c(c1_c), .d(c1_d), .e(c1_e), .f(c1_f), .g(c1_g), .h(c1_h), .i(c1_i));
    logicgate #(.WIDTH(8), .REG_OUT(0)) u_c8 (
        .clk(clk_c), .rst(rst_c), .a(a8), .b(b8),
        .c(c8_c), .d(c8_d), .e(c8_e), .f(c8_f), .g(c8_g), .h(c8_h), .i(c8_i));
    logicgate #(.WIDTH(4), .REG_OUT(0)) u_c4 (
        .clk(clk_c), .rst(rst_c), .a(a4), .b(b4),
        .c(c4_c), .d(c4_d), .e(c4_e), .f(c4_f), .g(c4_g), .h(c4_h), .i(c4_i));
    logicgate #(.WIDTH(1), .REG_OUT(1)) u_r1 (
        .clk(clk), .rst(rst), .a(ar1), .b(br1),
        .c(r1_c), .d(r1_d), .e(r1_e), .f(r1_f), .g(r1_g), .h(r1_h), .i(r1_i));
    logicgate #(.WIDTH(4), .REG_OUT(1)) u_r4 (
        .clk(clk), .rst(rst), .a(ar4), .b(br4),
        .c(r4_c), .d(r4_d), .e(r4_e), .f(r4_f), .g(r4_g), .h(r4_h), .i(r4_i));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: per bit, count how many operand bits are set and derive each gate from the count.
    function automatic logic [63:0] model(input int w, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] result;
        logic [63:0] field;
        int s;
        logic v;
        result = '0;
        for (int gi = 0; gi < 7; gi++) begin
            field = '0;
            for (int k = 0; k < w; k++) begin
                s = int'(a[k]) + int'(b[k]);
                case (gi)
                    0:       v = (s == 2);
                    1:       v = (s >= 1);
                    2:       v = (s != 2);
                    3:       v = (s == 0);
                    4:       v = (s == 1);
                    5:       v = (s != 1);
                    default: v = (a[k] == 1'b0);
                endcase
                field[k] = v;
            end
            result = (result << w) | field;
        end
        return result;
    endfunction

    // Packs seven observed outputs in the order c,d,e,f,g,h,i.
    function automatic logic [63:0] pack7(input int w,
        input logic [63:0] c, input logic [63:0] d, input logic [63:0] e, input logic [63:0] f,
        input logic [63:0] g, input logic [63:0] h, input logic [63:0] i);
        logic [63:0] r;
        r = c;
        r = (r << w) | d;
        r = (r << w) | e;
        r = (r << w) | f;
        r = (r << w) | g;
        r = (r << w) | h;
        r = (r << w) | i;
        return r;
    endfunction

    function automatic logic [63:0] obs_c1();
        return pack7(1, 64'(c1_c), 64'(c1_d), 64'(c1_e), 64'(c1_f), 64'(c1_g), 64'(c1_h), 64'(c1_i));
    endfunction
    function automatic logic [63:0] obs_c4();
        return pack7(4, 64'(c4_c), 64'(c4_d), 64'(c4_e), 64'(c4_f), 64'(c4_g), 64'(c4_h), 64'(c4_i));
    endfunction
    function automatic logic [63:0] obs_r1();
        return pack7(1, 64'(r1_c), 64'(r1_d), 64'(r1_e), 64'(r1_f), 64'(r1_g), 64'(r1_h), 64'(r1_i));
    endfunction
    function automatic logic [63:0] obs_r4();
        return pack7(4, 64'(r4_c), 64'(r4_d), 64'(r4_e), 64'(r4_f), 64'(r4_g), 64'(r4_h), 64'(r4_i));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [6:0] exp_tbl [4];
    int         order   [256];
    logic       do_rst;
    logic [7:0] pair;
    logic [63:0] exp_v;

    initial begin
        exp_tbl[0] = 7'b0011011;
        exp_tbl[1] = 7'b0110101;
        exp_tbl[2] = 7'b0110100;
        exp_tbl[3] = 7'b1100010;
        a1 = 1'b0; b1 = 1'b0; a8 = '0; b8 = '0; a4 = '0; b4 = '0;
        ar1 = 1'b0; br1 = 1'b0; ar4 = '0; br4 = '0;

        // combinational truth table, WIDTH=1
        for (int v = 0; v < 4; v++) begin
            a1 = v[1];
            b1 = v[0];
            #10;
            check_eq($sformatf("comb1_tt_%0d", v), obs_c1(), 64'(exp_tbl[v]));
            check_eq($sformatf("comb1_model_%0d", v), obs_c1(), model(1, 64'(a1), 64'(b1)));
        end

        // reset held, clock idle: combinational path unaffected
        rst_c = 1'b1;
        a1 = 1'b1; b1 = 1'b1;
        #10;
        check_eq("comb1_rst_c", 64'(c1_c), 64'd1);
        check_eq("comb1_rst_i", 64'(c1_i), 64'd0);
        rst_c = 1'b0;

        // WIDTH=8 directed vector
        a8 = 8'hF0; b8 = 8'hCC;
        #10;
        check_eq("comb8_c", 64'(c8_c), 64'hC0);
        check_eq("comb8_d", 64'(c8_d), 64'hFC);
        check_eq("comb8_e", 64'(c8_e), 64'h3F);
        check_eq("comb8_f", 64'(c8_f), 64'h03);
        check_eq("comb8_g", 64'(c8_g), 64'h3C);
        check_eq("comb8_h", 64'(c8_h), 64'hC3);
        check_eq("comb8_i", 64'(c8_i), 64'h0F);

        // registered: reset for two edges clears every output
        rst = 1'b1;
        ar1 = 1'b0; br1 = 1'b0; ar4 = '0; br4 = '0;
        tick();
        tick();
        check_eq("reg1_reset", obs_r1(), 64'd0);
        check_eq("reg4_reset", obs_r4(), 64'd0);

        // release with zero operands
        rst = 1'b0;
        tick();
        check_eq("reg1_release", obs_r1(), 64'(7'b0011011));
        check_eq("reg4_release", obs_r4(), model(4, 64'd0, 64'd0));

        // one-cycle latency, hold between edges, then reset discards in-flight result
        ar1 = 1'b1; br1 = 1'b0;
        tick();
        check_eq("reg1_edgeN", obs_r1(), 64'(7'b0110100));
        ar1 = 1'b1; br1 = 1'b1;
        #2;
        check_eq("reg1_hold", obs_r1(), 64'(7'b0110100));
        tick();
        check_eq("reg1_edgeN1", obs_r1(), 64'(7'b1100010));
        ar1 = 1'b0; br1 = 1'b1;
        rst = 1'b1;
        tick();
        check_eq("reg1_rst_mid", obs_r1(), 64'd0);
        rst = 1'b0;

        // exhaustive WIDTH=4 in shuffled order, with occasional random reset
        for (int n = 0; n < 256; n++) order[n] = n;
        for (int n = 255; n > 0; n--) begin
            int j;
            int t;
            j = int'($urandom_range(n, 0));
            t = order[n];
            order[n] = order[j];
            order[j] = t;
        end
        for (int n = 0; n < 256; n++) begin
            pair   = 8'(order[n]);
            do_rst = ($urandom_range(15, 0) == 0);
            a4  = pair[7:4]; b4  = pair[3:0];
            ar4 = pair[7:4]; br4 = pair[3:0];
            rst = do_rst;
            #1;
            check_eq($sformatf("comb4_%02h", pair), obs_c4(), model(4, 64'(pair[7:4]), 64'(pair[3:0])));
            tick();
            exp_v = do_rst ? 64'd0 : model(4, 64'(pair[7:4]), 64'(pair[3:0]));
            check_eq($sformatf("reg4_%02h_r%0d", pair, do_rst), obs_r4(), exp_v);
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/logicgate.md
# logicgate

Two-input bitwise gate bank producing seven elementary logic functions of operands `a` and `b` in parallel. It is a leaf primitive used wherever several gate results of the same operand pair are needed at once, and serves as the reference combinational block for the fundamentals library. Outputs are combinational by default. An optional output register stage is available for use in pipelined datapaths.

## Interface
- `WIDTH`, default 1: bit width of operands and of every result; all operations are bitwise.
- `REG_OUT`, default 0: 0 gives a purely combinational output path; 1 registers all seven results on `clk`.
- `clk`  input  1  clock; used only when `REG_OUT=1`.
- `rst`  input  1  reset, synchronous and active-high; used only when `REG_OUT=1`.
- `a`  input  WIDTH  operand A.
- `b`  input  WIDTH  operand B.
- `c`  output  WIDTH  `a AND b`.
- `d`  output  WIDTH  `a OR b`.
- `e`  output  WIDTH  `a NAND b`.
- `f`  output  WIDTH  `a NOR b`.
- `g`  output  WIDTH  `a XOR b`.
- `h`  output  WIDTH  `a XNOR b`.
- `i`  output  WIDTH  `NOT a`. Operand `b` has no effect on this output.
- One clock; reset is synchronous and active-high (`clk`, `rst`).

## Operation
- All seven functions are computed bitwise, per bit index k, from `a[k]` and `b[k]` only. There is no carry and no cross-bit interaction.
- `REG_OUT=0`:
  - Outputs are continuous functions of the inputs.
  - `clk` and `rst` are ignored. `rst` does not force any output value.
- `REG_OUT=1`:
  - Each output is a flop that captures its gate result on the rising edge of `clk`.
  - When `rst=1` at a rising edge, all outputs `c`..`i` become all-zeros. This applies to `e`, `f`, `h` and `i` too, even though their gate values for zero operands are ones.
  - Reset has priority over capture.
  - When `rst` deasserts, the next rising edge captures the current operand values.
- X or Z on an input bit may propagate only to the same bit of the outputs.
- No internal state exists other than the optional output register.

## Timing
- `REG_OUT=0`: zero-cycle latency; outputs settle within the same delta or time step as an input change. The combinational path has no clock involvement.
- `REG_OUT=1`: one-cycle latency. Operands sampled at edge N appear on the outputs after edge N and hold until edge N+1.
- Reset asserted mid-operation (`REG_OUT=1`): outputs are zero after the first rising edge with `rst=1`. A result in flight is discarded.
- Before the first clock edge with `REG_OUT=1`, outputs are undefined. Benches must apply `rst` for at least one edge.
- Operand changes between edges have no effect when `REG_OUT=1`.

## Structure
- Shared package `logicgate_pkg` holds:
  - the gate index constants: AND=0, OR=1, NAND=2, NOR=3, XOR=4, XNOR=5, NOT_A=6;
  - `NUM_GATES=7`;
  - a function returning a gate result given an index and two operands, for reuse by the bench scoreboard.
- One sub-module fits naturally: `logicgate_core`. It is purely combinational, WIDTH-parameterised and produces all seven results.
- The top level instantiates `logicgate_core` and uses a `generate` on `REG_OUT` to select either direct wiring or the synchronous-reset register stage.

## Test plan
- `REG_OUT=0`, `WIDTH=1`, drive (a,b)=(0,0),(0,1),(1,0),(1,1), 10 ns apart. Required outputs in order c,d,e,f,g,h,i:
  - (0,0) -> 0,0,1,1,0,1,1
  - (0,1) -> 0,1,1,0,1,0,1
  - (1,0) -> 0,1,1,0,1,0,0
  - (1,1) -> 1,1,0,0,0,1,0
- `REG_OUT=0`, `rst=1` held with no clock toggling, a=1, b=1 -> c=1, i=0. Confirms reset and clock have no effect on the combinational path.
- `REG_OUT=0`, `WIDTH=8`, a=8'hF0, b=8'hCC:
  - c=C0, d=FC, e=3F, f=03
  - g=3C, h=C3, i=0F
- `REG_OUT=1`, `WIDTH=1`: rst=1 for 2 edges -> all outputs 0. Then release with (a,b)=(0,0) -> after the next edge, e=f=h=i=1 and c=d=g=0.
- `REG_OUT=1`, `WIDTH=1`: apply (1,0) at edge N and (1,1) at edge N+1.
  - Outputs show the (1,0) results after N and the (1,1) results after N+1.
  - Assert rst before edge N+2 -> all outputs 0 after N+2.
- Random exhaustive check for `WIDTH=4`: all 256 operand pairs, both `REG_OUT` settings, compared against the `logicgate_pkg` function with the latency aligned.
